// File: rtl/aes_encipher_iter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : aes_encipher_iter
//  Purpose  : Iterative AES block encipher (128/192/256-bit keys). One round
//             takes 16/SBOX_LANES cycles. Round keys come from an external
//             combinational key store, addressed by round_idx.
//  Ports    : clk, rst_n     - clock, asynchronous active-low reset
//             start, abort   - launch / cancel an operation
//             keylen         - 0=128, 1=192, 2=256, 3=reserved
//             block_in       - plaintext (byte 0 = [127:120])
//             round_idx      - round key address (0 outside SUB)
//             round_key      - key for round_idx, same cycle
//             block_out      - ciphertext register
//             busy/done/err  - status (done and err are one-cycle pulses)
//  Revision : 1.0 - initial release
// ============================================================================
module aes_encipher_iter #(
  parameter int SBOX_LANES = 16,
  parameter int ENABLE_256 = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [1:0]   keylen,
  input  logic [127:0] block_in,
  output logic [3:0]   round_idx,
  input  logic [127:0] round_key,
  output logic [127:0] block_out,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_INIT = 2'd1;
  localparam logic [1:0] S_SUB  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Entry 0 sits in the most significant byte, so entry x is element 255-x.
  localparam logic [255:0][7:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[8'hff - x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte b of the block lives at bits [8*(15-b) +: 8]; state[r][c] = byte 4c+r.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[8*(15-(4*c+r)) +: 8] = s[8*(15-(4*((c+r)%4)+r)) +: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[8*(15-4*c) +: 8];
      a1 = s[8*(14-4*c) +: 8];
      a2 = s[8*(13-4*c) +: 8];
      a3 = s[8*(12-4*c) +: 8];
      o[8*(15-4*c) +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[8*(14-4*c) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[8*(13-4*c) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[8*(12-4*c) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  logic [1:0]   fsm;
  logic [127:0] data;
  logic [3:0]   round;
  logic [1:0]   lane;
  logic [3:0]   nr;
  logic [127:0] sub_out;
  logic [127:0] shifted;
  logic [127:0] round_out;
  logic         last_lane;
  logic         keylen_ok;
  logic [3:0]   nr_sel;

  // SubBytes datapath: either the whole block or the single column `lane`.
  if (SBOX_LANES == 16) begin : g_lanes16
    always_comb begin
      sub_out = data;
      for (int i = 0; i < 16; i++) begin
        sub_out[8*i +: 8] = sbox(data[8*i +: 8]);
      end
    end
    assign last_lane = 1'b1;
  end else if (SBOX_LANES == 4) begin : g_lanes4
    logic [31:0] col_in;
    logic [31:0] col_sub;
    // Column c occupies bits [32*(3-c) +: 32]; 3-c is simply ~lane.
    always_comb begin
      col_sub = '0;
      col_in  = data[{~lane, 5'b00000} +: 32];
      for (int r = 0; r < 4; r++) begin
        col_sub[8*r +: 8] = sbox(col_in[8*r +: 8]);
      end
      sub_out = data;
      sub_out[{~lane, 5'b00000} +: 32] = col_sub;
    end
    assign last_lane = (lane == 2'd3);
  end else begin : g_bad_lanes
    $error("aes_encipher_iter: SBOX_LANES must be 16 or 4");
  end

  // The final lane's substitution feeds the rest of the round directly.
  always_comb begin
    shifted   = shift_rows(sub_out);
    round_out = ((round == nr) ? shifted : mix_columns(shifted)) ^ round_key;
  end

  assign keylen_ok = (keylen == 2'd0) ||
                     ((ENABLE_256 != 0) && ((keylen == 2'd1) || (keylen == 2'd2)));
  assign nr_sel    = 4'd10 + {1'b0, keylen, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm       <= S_IDLE;
      data      <= '0;
      round     <= '0;
      lane      <= '0;
      nr        <= '0;
      block_out <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (fsm)
        S_IDLE, S_DONE: begin
          fsm <= S_IDLE;
          // abort outranks start; a cancelled start is not an error
          if (start && !abort) begin
            if (keylen_ok) begin
              fsm  <= S_INIT;
              data <= block_in;
              nr   <= nr_sel;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_INIT: begin
          if (abort) begin
            fsm <= S_IDLE;
          end else begin
            data  <= data ^ round_key;
            round <= 4'd1;
            lane  <= 2'd0;
            fsm   <= S_SUB;
          end
        end
        S_SUB: begin
          if (abort) begin
            fsm   <= S_IDLE;
            round <= '0;
            lane  <= '0;
          end else if (last_lane) begin
            data <= round_out;
            lane <= 2'd0;
            if (round == nr) begin
              fsm       <= S_DONE;
              block_out <= round_out;
              round     <= '0;
            end else begin
              round <= round + 4'd1;
            end
          end else begin
            data <= sub_out;
            lane <= lane + 2'd1;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign busy      = (fsm == S_INIT) || (fsm == S_SUB);
  assign done      = (fsm == S_DONE);
  assign round_idx = (fsm == S_SUB) ? round : 4'd0;

endmodule
`default_nettype wire
